panda_risc_v_gpr_file: RTL

- 32x32-bit general-purpose register file; the responder end of the decoder's REQ/GRANT register-file read ports #0/#1.
- Also serves one auxiliary read requester from the fetch unit (JALR base-address prefetch), which shares physical read port #0 with decoder port #0.
- Two write ports: commit writeback and long-instruction writeback (LSU load / mul / div).

---
 rtl/panda_risc_v_gpr_file_pkg.sv | 33 +++
 rtl/panda_risc_v_gpr_rd_arb.sv | 28 ++
 rtl/panda_risc_v_gpr_file.sv | 89 ++++++++
 3 files changed

// File: rtl/panda_risc_v_gpr_file_pkg.sv
// Shared constants, types and write-forwarding helper for the panda RISC-V GPR file.
// The helper is only called when GPR_WR_BYPASS_EN is defined.
package panda_risc_v_gpr_file_pkg;

   localparam int GPR_NUM        = 32;
   localparam int GPR_WIDTH      = 32;
   localparam int GPR_ADDR_WIDTH = 5;
   localparam logic [GPR_ADDR_WIDTH-1:0] GPR_X0_ADDR = 5'd0;

   typedef logic [GPR_WIDTH-1:0]      gpr_data_t;
   typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;

   // Commit writeback (p0) overrides long-instruction writeback (p1) when both match.
   function automatic gpr_data_t gpr_fwd(
      input gpr_data_t stored,
      input gpr_addr_t addr,
      input logic      wen0,
      input gpr_addr_t waddr0,
      input gpr_data_t din0,
      input logic      wen1,
      input gpr_addr_t waddr1,
      input gpr_data_t din1
   );
      gpr_data_t v;
      v = stored;
      if (addr != GPR_X0_ADDR) begin
         if (wen1 && (waddr1 == addr)) v = din1;
         if (wen0 && (waddr0 == addr)) v = din0;
      end
      return v;
   endfunction

endpackage

// File: rtl/panda_risc_v_gpr_rd_arb.sv
// Round-robin arbiter for physical read port #0, shared by decoder p0 and the fetch unit.
module panda_risc_v_gpr_rd_arb (
   input  logic clk,
   input  logic sys_resetn,
   input  logic dcd_req,
   input  logic ifu_req,
   output logic dcd_grant,
   output logic ifu_grant,
   output logic sel_ifu
);

   logic rr_ifu_prio;
   logic contest;

   assign contest   = dcd_req & ifu_req;
   assign ifu_grant = ifu_req & (~dcd_req | rr_ifu_prio);
   assign dcd_grant = dcd_req & (~ifu_req | ~rr_ifu_prio);
   assign sel_ifu   = ifu_grant;

   // Priority only moves on a contested cycle, so the loser always wins the next contest.
   always_ff @(posedge clk or negedge sys_resetn) begin
      if (!sys_resetn)
         rr_ifu_prio <= 1'b0;
      else if (contest)
         rr_ifu_prio <= ~rr_ifu_prio;
   end

endmodule

// File: rtl/panda_risc_v_gpr_file.sv
// 32x32 GPR file: two zero-latency REQ/GRANT read paths plus fetch-unit read, two write ports.
// Optional same-cycle write forwarding on reads is enabled by GPR_WR_BYPASS_EN.
module panda_risc_v_gpr_file
   import panda_risc_v_gpr_file_pkg::*;
#(
   parameter int simulation_delay = 1
) (
   input  logic        clk,
   input  logic        sys_resetn,
   input  logic        dcd_reg_file_rd_p0_req,
   input  logic [4:0]  dcd_reg_file_rd_p0_addr,
   output logic        dcd_reg_file_rd_p0_grant,
   output logic [31:0] dcd_reg_file_rd_p0_dout,
   input  logic        dcd_reg_file_rd_p1_req,
   input  logic [4:0]  dcd_reg_file_rd_p1_addr,
   output logic        dcd_reg_file_rd_p1_grant,
   output logic [31:0] dcd_reg_file_rd_p1_dout,
   input  logic        ifu_reg_file_rd_req,
   input  logic [4:0]  ifu_reg_file_rd_addr,
   output logic        ifu_reg_file_rd_grant,
   output logic [31:0] ifu_reg_file_rd_dout,
   input  logic        reg_file_wen_p0,
   input  logic [4:0]  reg_file_waddr_p0,
   input  logic [31:0] reg_file_din_p0,
   input  logic        reg_file_wen_p1,
   input  logic [4:0]  reg_file_waddr_p1,
   input  logic [31:0] reg_file_din_p1
);

   // The cycle-accurate model carries no update delay; a negative value is a setup error.
   if (simulation_delay < 0) begin : g_delay_check
      $error("simulation_delay must be non-negative");
   end

   gpr_data_t gpr [GPR_NUM];
   logic      sel_ifu;
   gpr_addr_t phys0_addr, side_addr;
   gpr_data_t phys0_dout, side_dout;

   panda_risc_v_gpr_rd_arb u_rd_arb (
      .clk        (clk),
      .sys_resetn (sys_resetn),
      .dcd_req    (dcd_reg_file_rd_p0_req),
      .ifu_req    (ifu_reg_file_rd_req),
      .dcd_grant  (dcd_reg_file_rd_p0_grant),
      .ifu_grant  (ifu_reg_file_rd_grant),
      .sel_ifu    (sel_ifu)
   );

   assign dcd_reg_file_rd_p1_grant = dcd_reg_file_rd_p1_req;

   // Entry 0 is only ever reset, so x0 reads as zero and writes to it are dropped.
   always_ff @(posedge clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         for (int i = 0; i < GPR_NUM; i++) gpr[i] <= '0;
      end else begin
         for (int i = 1; i < GPR_NUM; i++) begin
            if (reg_file_wen_p0 && (reg_file_waddr_p0 == GPR_ADDR_WIDTH'(i)))
               gpr[i] <= reg_file_din_p0;
            else if (reg_file_wen_p1 && (reg_file_waddr_p1 == GPR_ADDR_WIDTH'(i)))
               gpr[i] <= reg_file_din_p1;
         end
      end
   end

   // Physical port #0 follows the winner; the loser still sees its own address via side path.
   assign phys0_addr = sel_ifu ? ifu_reg_file_rd_addr : dcd_reg_file_rd_p0_addr;
   assign side_addr  = sel_ifu ? dcd_reg_file_rd_p0_addr : ifu_reg_file_rd_addr;

`ifdef GPR_WR_BYPASS_EN
   assign phys0_dout = gpr_fwd(gpr[phys0_addr], phys0_addr,
                               reg_file_wen_p0, reg_file_waddr_p0, reg_file_din_p0,
                               reg_file_wen_p1, reg_file_waddr_p1, reg_file_din_p1);
   assign side_dout  = gpr_fwd(gpr[side_addr], side_addr,
                               reg_file_wen_p0, reg_file_waddr_p0, reg_file_din_p0,
                               reg_file_wen_p1, reg_file_waddr_p1, reg_file_din_p1);
   assign dcd_reg_file_rd_p1_dout = gpr_fwd(gpr[dcd_reg_file_rd_p1_addr], dcd_reg_file_rd_p1_addr,
                               reg_file_wen_p0, reg_file_waddr_p0, reg_file_din_p0,
                               reg_file_wen_p1, reg_file_waddr_p1, reg_file_din_p1);
`else
   assign phys0_dout = gpr[phys0_addr];
   assign side_dout  = gpr[side_addr];
   assign dcd_reg_file_rd_p1_dout = gpr[dcd_reg_file_rd_p1_addr];
`endif

   assign dcd_reg_file_rd_p0_dout = sel_ifu ? side_dout : phys0_dout;
   assign ifu_reg_file_rd_dout    = sel_ifu ? phys0_dout : side_dout;

endmodule
